// File: rtl/l1_refill_responder.sv
// rtl/l1_refill_responder.sv - queued L1 block-refill responder streaming rows from a synchronous SRAM
// Optional feature: define L1_REFILL_CWF_EN for critical-word-first beat ordering.
module l1_refill_responder #(
  parameter int PADDR_BITS  = 32,
  parameter int BLOCK_BYTES = 64,
  parameter int DATA_BITS   = 128,
  parameter int N_MSHRS     = 4,
  localparam int BEATS      = BLOCK_BYTES * 8 / DATA_BITS,
  localparam int BEAT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int ID_BITS    = $clog2(N_MSHRS),
  localparam int OFF_BITS   = $clog2(BLOCK_BYTES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [PADDR_BITS-1:0] req_addr,
  input  logic [ID_BITS-1:0]    req_id,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_BITS-1:0]  resp_data,
  output logic [ID_BITS-1:0]    resp_id,
  output logic [BEAT_BITS-1:0]  resp_beat,
  output logic                  resp_last,
  output logic                  mem_rd_en,
  output logic [PADDR_BITS-1:0] mem_rd_addr,
  input  logic [DATA_BITS-1:0]  mem_rd_data,
  output logic                  busy
);

  localparam int                   ROW_BITS  = $clog2(DATA_BITS / 8);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);
  localparam logic [ID_BITS:0]     DEPTH     = (ID_BITS + 1)'(N_MSHRS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SEND} state_t;

  // Request queue
  logic [PADDR_BITS-1:0] fifo_addr_q [N_MSHRS];
  logic [BEAT_BITS-1:0]  fifo_beat_q [N_MSHRS];
  logic [ID_BITS-1:0]    fifo_id_q   [N_MSHRS];
  logic [ID_BITS-1:0]    wr_ptr_q, rd_ptr_q;
  logic [ID_BITS:0]      occ_q, occ_d;
  logic                  full, empty, push, pop;
  logic [PADDR_BITS-1:0] req_blk;
  logic [BEAT_BITS-1:0]  req_start;
  logic                  unused_req_offset;

  assign full      = (occ_q == DEPTH);
  assign empty     = (occ_q == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign req_blk   = {req_addr[PADDR_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
  assign unused_req_offset = ^req_addr[OFF_BITS-1:0];

`ifdef L1_REFILL_CWF_EN
  always_comb begin
    req_start = '0;
    if (BEATS > 1) req_start = req_addr[OFF_BITS-1 -: BEAT_BITS];
  end
`else
  assign req_start = '0;
`endif

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + (ID_BITS + 1)'(1);
      2'b01:   occ_d = occ_q - (ID_BITS + 1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      occ_q <= occ_d;
      if (push) wr_ptr_q <= wr_ptr_q + ID_BITS'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ID_BITS'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= req_blk;
      fifo_beat_q[wr_ptr_q] <= req_start;
      fifo_id_q[wr_ptr_q]   <= req_id;
    end
  end

  // Burst sequencer
  state_t               state_q, state_d;
  logic [BEAT_BITS-1:0] beat_q, beat_d, cnt_q, cnt_d;
  logic [ID_BITS-1:0]   id_q, id_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 first_q, first_d;
  logic                 is_last;

  assign is_last = (cnt_q == LAST_BEAT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      data_q  <= data_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    data_d     = data_q;
    first_d    = 1'b0;
    pop        = 1'b0;
    mem_rd_en  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_ISSUE;
          beat_d  = fifo_beat_q[rd_ptr_q];
          cnt_d   = '0;
          id_d    = fifo_id_q[rd_ptr_q];
        end
      end
      S_ISSUE: begin
        mem_rd_en = 1'b1;
        first_d   = 1'b1;
        state_d   = S_SEND;
      end
      S_SEND: begin
        resp_valid = 1'b1;
        // SRAM data is only valid in the first SEND cycle; keep it for stalls
        if (first_q) data_d = mem_rd_data;
        if (resp_ready) begin
          if (is_last) begin
            pop     = 1'b1;
            state_d = S_IDLE;
          end else begin
            beat_d  = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_BITS'(1);
            cnt_d   = cnt_q + BEAT_BITS'(1);
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Row offset stays below OFF_BITS, so OR-ing into the block address cannot carry
  assign mem_rd_addr = fifo_addr_q[rd_ptr_q] | (PADDR_BITS'(beat_q) << ROW_BITS);
  assign resp_data   = first_q ? mem_rd_data : data_q;
  assign resp_id     = id_q;
  assign resp_beat   = beat_q;
  assign resp_last   = (state_q == S_SEND) && is_last;
  assign busy        = !empty || (state_q != S_IDLE);

endmodule

// File: doc/l1_refill_responder.md
# l1_refill_responder

Memory-side responder for L1 data-cache refills. It accepts block-refill requests from the cache's MSHRs, reads the block one row at a time from a synchronous backing SRAM, and returns it as a sequence of row-wide beats with valid/ready flow control. Up to N_MSHRS requests are queued in order.

## Interface
Parameters:
- PADDR_BITS, 32, physical address width.
- BLOCK_BYTES, 64, cache block size in bytes; power of two.
- DATA_BITS, 128, beat (row) width; BLOCK_BYTES*8 must be a multiple of it.
- N_MSHRS, 4, request queue depth and ID space; power of two, ≥2.
- Derived: BEATS = BLOCK_BYTES*8/DATA_BITS (default 4); BEAT_BITS = max(1, clog2(BEATS)); ID_BITS = clog2(N_MSHRS); OFF_BITS = clog2(BLOCK_BYTES).

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  refill request present.
- req_ready  out  1  equals queue not full.
- req_addr  in  PADDR_BITS  any byte address inside the block.
- req_id  in  ID_BITS  MSHR tag, returned unchanged.
- resp_valid  out  1  beat present.
- resp_ready  in  1  cache accepts the beat.
- resp_data  out  DATA_BITS  beat payload.
- resp_id  out  ID_BITS  tag of the request being served.
- resp_beat  out  BEAT_BITS  row index of this beat within the block.
- resp_last  out  1  final beat of the block.
- mem_rd_en  out  1  SRAM read strobe.
- mem_rd_addr  out  PADDR_BITS  byte address of the row being read, DATA_BITS/8 aligned.
- mem_rd_data  in  DATA_BITS  read data, valid exactly one cycle after mem_rd_en.
- busy  out  1  queue non-empty or FSM not IDLE.

## Operation
- Queue: N_MSHRS-entry FIFO of {block address with OFF_BITS low bits zeroed, start beat, id}. Enqueue on req_valid && req_ready. No bypass: when full, req_ready=0 even in a pop cycle.
- FSM states: IDLE, ISSUE, SEND.
  - IDLE: if queue non-empty, go to ISSUE. Load beat counter with the start beat and beat count with 0.
  - ISSUE: assert mem_rd_en for one cycle. mem_rd_addr = block address + beat*(DATA_BITS/8). Go to SEND. On the following edge, capture mem_rd_data into the resp_data register.
  - SEND: resp_valid=1. Hold resp_data, resp_id, resp_beat and resp_last stable until resp_ready.
    - On handshake with resp_last=1: pop the queue and go to IDLE.
    - On any other handshake: beat = (beat+1) mod BEATS, increment the count, go to ISSUE.
- resp_last = (count == BEATS-1).
- Beat arithmetic is modulo BEATS in BEAT_BITS bits; the address add never carries out of the block.
- Requests are served strictly in acceptance order. The ID is not checked for duplicates.
- Reset values: resp_valid=0, mem_rd_en=0, resp_data=0, resp_id=0, resp_beat=0, resp_last=0, busy=0, queue empty (so req_ready=1), FSM in IDLE.
- Reset mid-burst drops the burst and all queued requests. No further beats are emitted.

## Timing
- Request accepted at edge of cycle T. Then:
  - T+1: IDLE sees the queue non-empty.
  - T+2: ISSUE, mem_rd_en=1.
  - T+3: first beat with resp_valid=1.
- Each later beat: 2 cycles after the previous handshake (ISSUE then SEND) when resp_ready is held high.
- With resp_ready always high, the full block takes 2*BEATS cycles from the first ISSUE. The next request's ISSUE comes 2 cycles after the last handshake (via IDLE).
- Stalling resp_ready delays only that beat. No read is issued while a beat is pending.
- Simultaneous enqueue and dequeue when not full: both take effect and the occupancy is unchanged.

## Configuration
- L1_REFILL_CWF_EN defined: critical-word-first.
  - Start beat = req_addr[OFF_BITS-1 : OFF_BITS-BEAT_BITS].
  - Beats wrap modulo BEATS; resp_last marks the BEATS-th beat sent.
- Not defined: the start beat is always 0 and the low req_addr bits are ignored; beats are sent in order 0..BEATS-1.

## Test plan
- Single request, addr 0x1000_0040, id 2, resp_ready=1:
  - mem_rd_addr sequence 0x1000_0040, 0x1000_0050, 0x1000_0060, 0x1000_0070.
  - resp_beat 0,1,2,3; resp_last only on beat 3; first resp_valid at T+3; resp_id=2 on all beats.
- CWF: addr 0x1000_0068 with the macro on gives beats 2,3,0,1, last on beat 1. With the macro off, the same request gives beats 0,1,2,3.
- Backpressure: resp_ready low 5 cycles on beat 1. resp_data and resp_beat hold stable, mem_rd_en stays low, and the beat completes after release.
- Queue full: 5 back-to-back requests, ids 0–3 then 1. req_ready drops after the 4th and rises the cycle after the first burst's last handshake. Responses are ordered 0,1,2,3,1.
- Reset asserted in SEND of beat 2: next cycle resp_valid=0, busy=0, req_ready=1. A new request afterwards starts again at T+3.
